// File: rtl/fp_cmp_class_d.sv
// Two-stage binary64 compare/classify unit: FEQ.D, FLT.D, FLE.D, FCLASS.D.
// Returns the integer-side result and the NV flag with a passthrough tag.
module fp_cmp_class_d #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic             out_nv,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic sign;
    logic ezero;
    logic emax;
    logic fzero;
    logic fmsb;
  } dec_t;

  function automatic dec_t decode(input logic [63:0] x);
    dec_t d;
    d.sign  = x[63];
    d.ezero = (x[62:52] == 11'h000);
    d.emax  = (x[62:52] == 11'h7ff);
    d.fzero = (x[51:0] == 52'd0);
    d.fmsb  = x[51];
    return d;
  endfunction

  logic             s1_valid;
  dec_t             s1_a;
  dec_t             s1_b;
  logic             s1_lt;
  logic             s1_eq;
  logic [1:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic s1_adv;
  logic s2_adv;
  logic accept;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_lt    <= 1'b0;
      s1_eq    <= 1'b0;
      s1_op    <= 2'b00;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_a   <= decode(in_a);
        s1_b   <= decode(in_b);
        s1_lt  <= (in_a[62:0] < in_b[62:0]);
        s1_eq  <= (in_a[62:0] == in_b[62:0]);
        s1_op  <= in_op;
        s1_tag <= in_tag;
      end
    end
  end

  logic       nan_a, nan_b;
  logic       snan_a, snan_b;
  logic       any_nan, any_snan;
  logic       both_zero;
  logic       rel_lt, rel_eq;
  logic [9:0] cls;
  logic [63:0] res;
  logic       nv;

  assign nan_a     = s1_a.emax && !s1_a.fzero;
  assign nan_b     = s1_b.emax && !s1_b.fzero;
  assign snan_a    = nan_a && !s1_a.fmsb;
  assign snan_b    = nan_b && !s1_b.fmsb;
  assign any_nan   = nan_a || nan_b;
  assign any_snan  = snan_a || snan_b;
  assign both_zero = s1_a.ezero && s1_a.fzero && s1_b.ezero && s1_b.fzero;

  // Sign-magnitude ordering; a negative pair flips the magnitude relation.
  always_comb begin
    rel_eq = 1'b0;
    rel_lt = 1'b0;
    if (!any_nan) begin
      if (both_zero) begin
        rel_eq = 1'b1;
      end else if (s1_a.sign != s1_b.sign) begin
        rel_lt = s1_a.sign;
      end else begin
        rel_eq = s1_eq;
        rel_lt = s1_a.sign ? (!s1_lt && !s1_eq) : s1_lt;
      end
    end
  end

  always_comb begin
    cls = 10'd0;
    unique case (1'b1)
      snan_a:
        cls = 10'h100;
      nan_a && !snan_a:
        cls = 10'h200;
      s1_a.emax && s1_a.fzero:
        cls = s1_a.sign ? 10'h001 : 10'h080;
      s1_a.ezero && s1_a.fzero:
        cls = s1_a.sign ? 10'h008 : 10'h010;
      s1_a.ezero && !s1_a.fzero:
        cls = s1_a.sign ? 10'h004 : 10'h020;
      default:
        cls = s1_a.sign ? 10'h002 : 10'h040;
    endcase
  end

  always_comb begin
    res = 64'd0;
    nv  = 1'b0;
    unique case (s1_op)
      2'b00: begin
        res[0] = rel_lt || rel_eq;
        nv     = any_nan;
      end
      2'b01: begin
        res[0] = rel_lt;
        nv     = any_nan;
      end
      2'b10: begin
        res[0] = rel_eq;
        nv     = any_snan;
      end
      default: begin
        res[9:0] = cls;
        nv       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= 64'd0;
      out_nv     <= 1'b0;
      out_tag    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res;
        out_nv     <= nv;
        out_tag    <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_cmp_class_d.sv
// Scoreboard bench for fp_cmp_class_d: random and directed ops checked
// against a real-valued reference model.
module tb_fp_cmp_class_d;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [63:0] in_a = 64'd0;
  logic [63:0] in_b = 64'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic        out_nv;
  logic [4:0]  out_tag;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  bit rand_ready = 0;
  bit rand_flush = 0;

  typedef struct {
    logic [63:0] res;
    logic        nv;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];

  fp_cmp_class_d #(.TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_nv(out_nv), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic bit is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7ff) && (x[51:0] != 52'd0);
  endfunction

  function automatic bit is_snan(input logic [63:0] x);
    return is_nan(x) && !x[51];
  endfunction

  function automatic exp_t model(input logic [1:0] op,
                                 input logic [63:0] a,
                                 input logic [63:0] b,
                                 input logic [4:0] tag);
    exp_t e;
    real ra, rb;
    bit nan;
    int k;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    nan = is_nan(a) || is_nan(b);
    e.res = 64'd0;
    e.nv = 1'b0;
    e.tag = tag;
    case (op)
      2'd0: begin e.res[0] = !nan && (ra <= rb); e.nv = nan; end
      2'd1: begin e.res[0] = !nan && (ra < rb);  e.nv = nan; end
      2'd2: begin
        e.res[0] = !nan && (ra == rb);
        e.nv = is_snan(a) || is_snan(b);
      end
      default: begin
        if (is_nan(a)) k = a[51] ? 9 : 8;
        else if (a[62:52] == 11'h7ff) k = a[63] ? 0 : 7;
        else if (a[62:0] == 63'd0) k = a[63] ? 3 : 4;
        else if (a[62:52] == 11'h000) k = a[63] ? 2 : 5;
        else k = a[63] ? 1 : 6;
        e.res = 64'd1 << k;
      end
    endcase
    return e;
  endfunction

  // Expected results are queued at acceptance.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      q.push_back(model(in_op, in_a, in_b, in_tag));
      acc_cnt++;
    end
  end

  // Monitor peeks while stalled, pops on transfer; flush kills the rest.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got res=%h tag=%h, none expected",
                   out_result, out_tag);
        end else if (out_result !== q[0].res || out_nv !== q[0].nv ||
                     out_tag !== q[0].tag) begin
          errors++;
          $display("FAIL result got res=%h nv=%b tag=%h exp res=%h nv=%b tag=%h",
                   out_result, out_nv, out_tag, q[0].res, q[0].nv, q[0].tag);
        end
        if (out_ready && q.size() != 0) void'(q.pop_front());
      end
      if (flush) q.delete();
    end
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    if (rand_flush) flush = ($urandom_range(0, 49) == 0);
    else flush = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    acc = 0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout got in_ready=0 exp 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got pending=%0d exp 0", q.size());
      q.delete();
    end
    repeat (2) tick();
  endtask

  logic [63:0] specials [16] = '{
    64'h0000000000000000, 64'h8000000000000000, 64'h3FF0000000000000,
    64'hBFF0000000000000, 64'h4000000000000000, 64'h7FF0000000000000,
    64'hFFF0000000000000, 64'h7FF0000000000001, 64'h7FF8000000000000,
    64'hFFF8000000000000, 64'h0000000000000001, 64'h8000000000000001,
    64'h7FEFFFFFFFFFFFFF, 64'h000FFFFFFFFFFFFF, 64'h0010000000000000,
    64'hC000000000000000
  };

  function automatic logic [63:0] pick();
    if ($urandom_range(0, 1) == 0) return specials[$urandom_range(0, 15)];
    return {$urandom, $urandom};
  endfunction

  initial begin
    int base;
    logic [63:0] a, b;
    #12;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_result", out_result, 64'd0);
    chk("reset_out_nv_tag", {58'd0, out_nv, out_tag}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Two-cycle latency on an empty pipe.
    issue(2'd1, 64'h3FF0000000000000, 64'h4000000000000000, 5'd1);
    @(negedge clk);
    chk("lat_edge1_valid", {63'd0, out_valid}, 64'd0);
    tick();
    @(negedge clk);
    chk("lat_edge2_valid", {63'd0, out_valid}, 64'd1);
    chk("flt_1_2_result", out_result, 64'd1);
    drain();

    issue(2'd2, 64'h0, 64'h8000000000000000, 5'd2);
    issue(2'd0, 64'h0, 64'h8000000000000000, 5'd3);
    issue(2'd1, 64'h0, 64'h8000000000000000, 5'd4);
    issue(2'd2, 64'h7FF0000000000001, 64'h3FF0000000000000, 5'd5);
    issue(2'd2, 64'h7FF8000000000000, 64'h3FF0000000000000, 5'd6);
    issue(2'd0, 64'h7FF8000000000000, 64'h3FF0000000000000, 5'd7);
    issue(2'd3, 64'hFFF0000000000000, 64'h0, 5'd8);
    issue(2'd3, 64'h0000000000000001, 64'h0, 5'd9);
    issue(2'd3, 64'h7FF8000000000000, 64'h0, 5'd10);
    issue(2'd1, 64'hC000000000000000, 64'hBFF0000000000000, 5'd11);
    drain();

    // Back-to-back with downstream stalled for three cycles.
    out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        issue(2'd1, 64'h3FF0000000000000, 64'h4000000000000000, 5'd12);
        issue(2'd0, 64'h4000000000000000, 64'h3FF0000000000000, 5'd13);
        issue(2'd3, 64'h8000000000000000, 64'h0, 5'd14);
        issue(2'd2, 64'h7FF0000000000000, 64'h7FF0000000000000, 5'd15);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_accepted", 64'(acc_cnt - base), 64'd2);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two ops in flight.
    out_ready = 1'b0;
    issue(2'd1, 64'h3FF0000000000000, 64'h4000000000000000, 5'd16);
    issue(2'd1, 64'h4000000000000000, 64'h3FF0000000000000, 5'd17);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    drain();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    issue(2'd3, 64'h7FF0000000000000, 64'h0, 5'd18);
    issue(2'd0, 64'h3FF0000000000000, 64'h3FF0000000000000, 5'd19);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_result", out_result, 64'd0);
    chk("arst_out_tag", {59'd0, out_tag}, 64'd0);
    q.delete();
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("arst_no_result", {63'd0, out_valid}, 64'd0);
    drain();

    // Randomized traffic with random backpressure and flushes.
    rand_ready = 1;
    rand_flush = 1;
    for (int i = 0; i < 400; i++) begin
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? a : pick();
      issue(2'($urandom_range(0, 3)), a, b, 5'($urandom));
    end
    rand_flush = 0;
    flush = 1'b0;
    drain();
    rand_ready = 0;
    out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
